// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg
// Shared types and helpers for the sequence window monitor.
//   edge_mode_e : event-select encoding used on the edge_mode bus
//   select_edge : picks the channel event from its rise/fall strobes
package seq_mon_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_RSVD = 2'b11
  } edge_mode_e;

  // The reserved encoding behaves as rising-edge so a stray write cannot
  // silence a channel.
  function automatic logic select_edge(input edge_mode_e mode,
                                       input logic       rise,
                                       input logic       fall);
    case (mode)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/seq_mon_chan.sv
// seq_mon_chan
// One monitor channel: synchronises an async input, detects the selected
// edge, keeps a WINDOW-deep event history and a running count of it, and
// drives a hysteretic active level with a one-cycle hit on assertion.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   en, clear      : window advance enable / synchronous window flush
//   edge_mode      : event select (see edge_mode_e)
//   thr_hi, thr_lo : assert and release thresholds
//   idx            : shared ring-buffer slot for this cycle
//   in_sig         : asynchronous input line
//   count          : events within the current window
//   active, hit    : hysteretic level and its rising-edge pulse
module seq_mon_chan
  import seq_mon_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1),
  parameter int IDX_W  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       edge_mode,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [IDX_W-1:0] idx,
  input  logic             in_sig,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             hit
);

  localparam int NW = CNT_W + 1;

  logic              s1, s2, prev;
  logic              rise, fall, ev, expired;
  logic [WINDOW-1:0] buf_q;
  logic [NW-1:0]     nxt;
  logic [CNT_W-1:0]  lo_eff;

  // Synchroniser and edge history run unconditionally so that en and clear
  // never create or hide an edge on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= in_sig;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Count is always the popcount of the buffer, so subtracting the expiring
  // bit cannot underflow and the sum cannot exceed WINDOW.
  always_comb begin
    rise    = s2 & ~prev;
    fall    = ~s2 & prev;
    ev      = select_edge(edge_mode_e'(edge_mode), rise, fall);
    expired = buf_q[idx];
    nxt     = {1'b0, count} - NW'(expired) + NW'(ev);
    lo_eff  = (thr_lo < thr_hi) ? thr_lo : thr_hi;
  end

  // Window update and hysteresis; only enabled cycles move the window or
  // re-evaluate the level, and clear wins over en.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      buf_q  <= '0;
      count  <= '0;
      active <= 1'b0;
      hit    <= 1'b0;
    end else if (en) begin
      buf_q[idx] <= ev;
      count      <= nxt[CNT_W-1:0];
      hit        <= 1'b0;
      if (thr_hi == '0) begin
        active <= 1'b0;
      end else if (!active && (nxt >= {1'b0, thr_hi})) begin
        active <= 1'b1;
        hit    <= 1'b1;
      end else if (active && (nxt < {1'b0, lo_eff})) begin
        active <= 1'b0;
      end
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_window_monitor.sv
// seq_window_monitor
// Multi-channel sliding-window edge counter with hysteretic thresholds.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   en             : window advance enable, all channels
//   clear          : synchronous flush of all window state
//   edge_mode      : 00 rise, 01 fall, 10 both, 11 rise
//   thr_hi, thr_lo : assert / release thresholds, shared
//   in_sig         : NCH asynchronous inputs
//   count          : per-channel count, channel i at [i*CNT_W +: CNT_W]
//   active, hit    : per-channel level and one-cycle assertion pulse
module seq_window_monitor
  import seq_mon_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int WINDOW = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic [1:0]           edge_mode,
  input  logic [CNT_W-1:0]     thr_hi,
  input  logic [CNT_W-1:0]     thr_lo,
  input  logic [NCH-1:0]       in_sig,
  output logic [NCH*CNT_W-1:0] count,
  output logic [NCH-1:0]       active,
  output logic [NCH-1:0]       hit
);

  localparam int               IDX_W    = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);

  logic [IDX_W-1:0] idx;

  // Shared ring slot; explicit wrap keeps non-power-of-two windows exact.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
    end else if (en) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    seq_mon_chan #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W),
      .IDX_W  (IDX_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clear     (clear),
      .edge_mode (edge_mode),
      .thr_hi    (thr_hi),
      .thr_lo    (thr_lo),
      .idx       (idx),
      .in_sig    (in_sig[i]),
      .count     (count[i*CNT_W +: CNT_W]),
      .active    (active[i]),
      .hit       (hit[i])
    );
  end

endmodule

// File: tb/tb_seq_window_monitor.sv
// tb_seq_window_monitor
// Directed bench for seq_window_monitor with NCH=2, WINDOW=5.
module tb_seq_window_monitor;

  localparam int NCH    = 2;
  localparam int WINDOW = 5;
  localparam int CNT_W  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 clear;
  logic [1:0]           edge_mode;
  logic [CNT_W-1:0]     thr_hi;
  logic [CNT_W-1:0]     thr_lo;
  logic [NCH-1:0]       in_sig;
  logic [NCH*CNT_W-1:0] count;
  logic [NCH-1:0]       active;
  logic [NCH-1:0]       hit;

  int checks = 0;
  int errors = 0;

  // Toggle burst: rises land at rows 3,5,7 and 15,17,19 (1-based)
  bit burst_in [20] = '{1,0,1,0,1,0,0,0,0,0,0,0,1,0,1,0,1,0,0,0};
  int burst_cnt[20] = '{0,0,1,1,2,2,3,2,2,1,1,0,0,0,1,1,2,2,3,2};
  bit burst_act[20] = '{0,0,0,0,0,0,1,1,1,1,1,0,0,0,0,0,0,0,1,1};
  bit burst_hit[20] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,1,0};

  // Two-cycle high pulse for the edge-mode runs
  bit em_in      [10] = '{1,1,0,0,0,0,0,0,0,0};
  int em_cnt_both[10] = '{0,0,1,1,2,2,2,1,1,0};
  int em_cnt_fall[10] = '{0,0,0,0,1,1,1,1,1,0};

  // Enable dropped for rows 5..8 in the middle of a burst
  bit en_in [14] = '{1,0,1,0,1,0,1,0,0,0,0,0,0,0};
  bit en_en [14] = '{1,1,1,1,0,0,0,0,1,1,1,1,1,1};
  int en_cnt[14] = '{0,0,1,1,1,1,1,1,2,2,2,1,1,0};

  // Input held high, clear on row 3 exactly when the rise arrives
  bit cl_clr[8] = '{0,0,1,0,0,0,0,0};

  // Both-edge pattern with events at offsets 1,2,4 mod 5: steady count 3
  bit wrap_in0 [20] = '{1,0,0,1,1,0,1,1,0,0,1,0,0,1,1,0,1,1,0,0};
  int wrap_cnt0[20] = '{0,0,1,2,2,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3};
  int wrap_cnt1[20] = '{0,0,1,2,2,2,2,1,0,0,0,0,0,0,0,0,0,0,0,0};

  seq_window_monitor #(
    .NCH    (NCH),
    .WINDOW (WINDOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (clear),
    .edge_mode (edge_mode),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .in_sig    (in_sig),
    .count     (count),
    .active    (active),
    .hit       (hit)
  );

  always #5 clk = ~clk;

  // Drive the inputs, take one rising edge, then settle before sampling
  task automatic applyStimulus(input logic [NCH-1:0] sig);
    in_sig = sig;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int c0, input int c1,
                             input logic [NCH-1:0] exp_act,
                             input logic [NCH-1:0] exp_hit);
    logic [NCH*CNT_W-1:0] exp_count;
    exp_count = {CNT_W'(c1), CNT_W'(c0)};
    checks++;
    assert (count === exp_count) else begin
      errors++;
      $error("[TB] FAIL %s count: observed %h expected %h", tag, count, exp_count);
    end
    checks++;
    assert (active === exp_act) else begin
      errors++;
      $error("[TB] FAIL %s active: observed %b expected %b", tag, active, exp_act);
    end
    checks++;
    assert (hit === exp_hit) else begin
      errors++;
      $error("[TB] FAIL %s hit: observed %b expected %b", tag, hit, exp_hit);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    clear     = 1'b0;
    edge_mode = 2'b00;
    thr_hi    = 3'd3;
    thr_lo    = 3'd1;
    in_sig    = '0;

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00);
      checkOutput($sformatf("reset%0d", i), 0, 0, 2'b00, 2'b00);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2'b00);
      checkOutput($sformatf("idle%0d", i), 0, 0, 2'b00, 2'b00);
    end

    $display("[TB] basic hit, decay and re-burst");
    for (int i = 0; i < 20; i++) begin
      applyStimulus({1'b0, burst_in[i]});
      checkOutput($sformatf("burst%0d", i), burst_cnt[i], 0,
                  {1'b0, burst_act[i]}, {1'b0, burst_hit[i]});
    end

    $display("[TB] clear while active");
    clear = 1'b1;
    applyStimulus(2'b00);
    checkOutput("clear_active", 0, 0, 2'b00, 2'b00);
    clear = 1'b0;

    $display("[TB] both-edge mode");
    edge_mode = 2'b10;
    for (int i = 0; i < 10; i++) begin
      applyStimulus({1'b0, em_in[i]});
      checkOutput($sformatf("both%0d", i), em_cnt_both[i], 0, 2'b00, 2'b00);
    end

    $display("[TB] fall mode");
    edge_mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      applyStimulus({1'b0, em_in[i]});
      checkOutput($sformatf("fall%0d", i), em_cnt_fall[i], 0, 2'b00, 2'b00);
    end

    $display("[TB] enable gap");
    edge_mode = 2'b00;
    for (int i = 0; i < 14; i++) begin
      en = en_en[i];
      applyStimulus({1'b0, en_in[i]});
      checkOutput($sformatf("engap%0d", i), en_cnt[i], 0, 2'b00, 2'b00);
    end
    en = 1'b1;

    $display("[TB] clear with input held high");
    for (int i = 0; i < 8; i++) begin
      clear = cl_clr[i];
      applyStimulus(2'b01);
      checkOutput($sformatf("clrhigh%0d", i), 0, 0, 2'b00, 2'b00);
    end
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00);
      checkOutput($sformatf("clrlow%0d", i), 0, 0, 2'b00, 2'b00);
    end

    $display("[TB] thr_hi zero disables");
    thr_hi = 3'd0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus({1'b0, burst_in[i]});
      checkOutput($sformatf("thr0_%0d", i), burst_cnt[i], 0, 2'b00, 2'b00);
    end

    $display("[TB] thr_lo above thr_hi");
    thr_hi = 3'd3;
    thr_lo = 3'd5;
    for (int i = 0; i < 12; i++) begin
      applyStimulus({1'b0, burst_in[i]});
      checkOutput($sformatf("lo5_%0d", i), burst_cnt[i], 0,
                  {1'b0, i == 6}, {1'b0, i == 6});
    end

    $display("[TB] wrap with simultaneous expiry and arrival");
    thr_lo    = 3'd1;
    edge_mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      applyStimulus({i == 0, wrap_in0[i]});
      checkOutput($sformatf("wrap%0d", i), wrap_cnt0[i], wrap_cnt1[i],
                  {1'b0, i >= 5}, {1'b0, i == 5});
    end

    $display("[TB] reset mid-burst");
    rst = 1'b1;
    applyStimulus(2'b01);
    checkOutput("rst_mid", 0, 0, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00);
      checkOutput($sformatf("post_rst%0d", i), 0, 0, 2'b00, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
